// File: rtl/pc_fetch_unit_if.sv
// Memory read port and opcode valid/ready handshake between the fetch unit and its neighbours.
// master = fetch unit side, slave = memory / control-unit side.
interface pc_fetch_unit_if #(
  parameter int unsigned ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_rdata;
  logic              mem_rvalid;
  logic              ins_valid;
  logic [7:0]        ins_opcode;
  logic              ins_ready;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_rdata,
    input  mem_rvalid,
    output ins_valid,
    output ins_opcode,
    input  ins_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_rdata,
    output mem_rvalid,
    input  ins_valid,
    input  ins_opcode,
    output ins_ready
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch sequencer: reads opcodes at the PC, presents plain opcodes to the control
// unit and resolves absolute jumps itself by fetching the 2-byte target and pulsing ins_con.
module pc_fetch_unit #(
  parameter int unsigned ADDR_W     = 16,
  parameter logic [7:0]  JMP_OPCODE = 8'h0C
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              finish_signal,
  pc_fetch_unit_if.master   bus,
  output logic              pc1,
  output logic              ins_con,
  output logic [7:0]        tr_pc,
  output logic [7:0]        mbr_pc,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [3:0] {
    StIdle,
    StReqOp,
    StWaitOp,
    StPresent,
    StGapHi,
    StReqHi,
    StWaitHi,
    StGapLo,
    StReqLo,
    StWaitLo,
    StLoad,
    StSettle,
    StHalted
  } state_e;

  state_e state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      bus.mem_addr   <= '0;
      bus.mem_rd     <= 1'b0;
      bus.ins_valid  <= 1'b0;
      bus.ins_opcode <= 8'h00;
      pc1            <= 1'b0;
      ins_con        <= 1'b0;
      tr_pc          <= 8'h00;
      mbr_pc         <= 8'h00;
      busy           <= 1'b0;
      halted         <= 1'b0;
    end else begin
      // Strobes default low so each is exactly one cycle wide.
      bus.mem_rd <= 1'b0;
      pc1        <= 1'b0;
      ins_con    <= 1'b0;

      unique case (state_q)
        StIdle, StSettle: begin
          if (finish_signal) begin
            state_q <= StHalted;
            halted  <= 1'b1;
            busy    <= 1'b0;
          end else if (fetch) begin
            state_q <= StReqOp;
            busy    <= 1'b1;
          end else begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end

        StReqOp: begin
          bus.mem_addr <= pc_addr;
          bus.mem_rd   <= 1'b1;
          state_q      <= StWaitOp;
        end

        StWaitOp: begin
          if (bus.mem_rvalid) begin
            if (bus.mem_rdata == JMP_OPCODE) begin
              pc1     <= 1'b1;
              state_q <= StGapHi;
            end else begin
              bus.ins_opcode <= bus.mem_rdata;
              bus.ins_valid  <= 1'b1;
              state_q        <= StPresent;
            end
          end
        end

        StPresent: begin
          if (bus.ins_valid && bus.ins_ready) begin
            bus.ins_valid <= 1'b0;
            pc1           <= 1'b1;
            state_q       <= StSettle;
          end
        end

        // Gap states let the PC apply the pc1 increment before the next address is sampled.
        StGapHi: state_q <= StReqHi;

        StReqHi: begin
          bus.mem_addr <= pc_addr;
          bus.mem_rd   <= 1'b1;
          state_q      <= StWaitHi;
        end

        StWaitHi: begin
          if (bus.mem_rvalid) begin
            tr_pc   <= bus.mem_rdata;
            pc1     <= 1'b1;
            state_q <= StGapLo;
          end
        end

        StGapLo: state_q <= StReqLo;

        StReqLo: begin
          bus.mem_addr <= pc_addr;
          bus.mem_rd   <= 1'b1;
          state_q      <= StWaitLo;
        end

        StWaitLo: begin
          if (bus.mem_rvalid) begin
            mbr_pc  <= bus.mem_rdata;
            ins_con <= 1'b1;
            state_q <= StLoad;
          end
        end

        StLoad: state_q <= StSettle;

        StHalted: begin
          state_q <= StHalted;
          halted  <= 1'b1;
          busy    <= 1'b0;
        end

        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit with a behavioural PC register and a latency-controlled
// byte memory.
module tb_pc_fetch_unit;
  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fetch = 1'b0;
  logic          finish_signal = 1'b0;
  logic [AW-1:0] pc_addr;
  logic          pc1, ins_con, busy, halted;
  logic [7:0]    tr_pc, mbr_pc;

  pc_fetch_unit_if #(.ADDR_W(AW)) bus ();

  pc_fetch_unit #(.ADDR_W(AW), .JMP_OPCODE(8'h0C)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch        (fetch),
    .pc_addr      (pc_addr),
    .finish_signal(finish_signal),
    .bus          (bus.master),
    .pc1          (pc1),
    .ins_con      (ins_con),
    .tr_pc        (tr_pc),
    .mbr_pc       (mbr_pc),
    .busy         (busy),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  // PC register model: pc1 has priority over ins_con.
  logic          pc_force = 1'b0;
  logic [AW-1:0] pc_force_val = '0;
  always @(posedge clk) begin
    if (pc_force)     pc_addr <= pc_force_val;
    else if (pc1)     pc_addr <= pc_addr + 16'd1;
    else if (ins_con) pc_addr <= {tr_pc, mbr_pc};
  end

  // Memory model: answers lat cycles after the mem_rd cycle; spur injects a stray rvalid.
  logic [7:0]    mem [0:1023];
  int unsigned   lat = 1;
  logic          pend;
  int unsigned   cnt;
  logic [AW-1:0] raddr;
  logic          spur = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend  <= 1'b0;
      cnt   <= 0;
      raddr <= '0;
    end else if (bus.mem_rd) begin
      pend  <= 1'b1;
      cnt   <= lat - 1;
      raddr <= bus.mem_addr;
    end else if (pend) begin
      if (cnt == 0) pend <= 1'b0;
      else          cnt  <= cnt - 1;
    end
  end
  assign bus.mem_rvalid = (pend && cnt == 0) || spur;
  assign bus.mem_rdata  = spur ? 8'hEE : mem[raddr[9:0]];

  // Pulse monitors.
  int            rd_cnt = 0, pc1_cnt = 0, con_cnt = 0, overlap_cnt = 0, wide_cnt = 0;
  logic          pc1_prev = 1'b0, con_prev = 1'b0;
  logic [AW-1:0] rd_addr [0:31];
  always @(posedge clk) begin
    if (bus.mem_rd) begin
      rd_addr[rd_cnt[4:0]] <= bus.mem_addr;
      rd_cnt <= rd_cnt + 1;
    end
    if (pc1) pc1_cnt <= pc1_cnt + 1;
    if (ins_con) con_cnt <= con_cnt + 1;
    if (pc1 && ins_con) overlap_cnt <= overlap_cnt + 1;
    if ((pc1 && pc1_prev) || (ins_con && con_prev)) wide_cnt <= wide_cnt + 1;
    pc1_prev <= pc1;
    con_prev <= ins_con;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int max, output int n, output logic ok);
    n  = 0;
    ok = 1'b0;
    while (n < max && !ok) begin
      @(negedge clk);
      n++;
      if (bus.ins_valid) ok = 1'b1;
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.mem_addr, bus.mem_rd, bus.ins_valid, bus.ins_opcode, pc1, ins_con,
                tr_pc, mbr_pc, busy, halted});
  endfunction

  typedef struct {
    logic          fetch;
    logic          ready;
    logic          rd;
    logic [AW-1:0] addr;
    logic          valid;
    logic [7:0]    op;
    logic          pc1;
    logic          busy;
  } vec_t;

  function automatic vec_t mk(logic f, logic r, logic rd, logic [AW-1:0] a, logic v,
                              logic [7:0] op, logic p, logic b);
    vec_t t;
    t.fetch = f; t.ready = r; t.rd = rd; t.addr = a;
    t.valid = v; t.op = op; t.pc1 = p; t.busy = b;
    return t;
  endfunction

  vec_t tbl [15];

  initial begin
    int   b_rd, b_pc1, b_con, b_ovl, b_wide, n;
    logic ok;

    for (int i = 0; i < 1024; i++) mem[i] = 8'h01;
    mem[5]   = 8'h03;
    mem[6]   = 8'h07;
    mem[10]  = 8'h0C;
    mem[11]  = 8'h01;
    mem[12]  = 8'h4D;
    mem[333] = 8'h05;
    mem[20]  = 8'h09;
    mem[30]  = 8'h11;

    // Plain opcode at 5 (ready low 3 valid cycles), then opcode at 6 with fetch dropped mid-way.
    tbl[0]  = mk(1, 0, 0, 16'd0, 0, 8'h00, 0, 1);
    tbl[1]  = mk(1, 0, 1, 16'd5, 0, 8'h00, 0, 1);
    tbl[2]  = mk(1, 0, 0, 16'd5, 0, 8'h00, 0, 1);
    tbl[3]  = mk(1, 0, 0, 16'd5, 1, 8'h03, 0, 1);
    tbl[4]  = mk(1, 0, 0, 16'd5, 1, 8'h03, 0, 1);
    tbl[5]  = mk(1, 0, 0, 16'd5, 1, 8'h03, 0, 1);
    tbl[6]  = mk(1, 0, 0, 16'd5, 1, 8'h03, 0, 1);
    tbl[7]  = mk(1, 1, 0, 16'd5, 0, 8'h03, 1, 1);
    tbl[8]  = mk(1, 0, 0, 16'd5, 0, 8'h03, 0, 1);
    tbl[9]  = mk(1, 0, 1, 16'd6, 0, 8'h03, 0, 1);
    tbl[10] = mk(0, 0, 0, 16'd6, 0, 8'h03, 0, 1);
    tbl[11] = mk(0, 0, 0, 16'd6, 1, 8'h07, 0, 1);
    tbl[12] = mk(0, 1, 0, 16'd6, 0, 8'h07, 1, 1);
    tbl[13] = mk(0, 0, 0, 16'd6, 0, 8'h07, 0, 0);
    tbl[14] = mk(0, 0, 0, 16'd6, 0, 8'h07, 0, 0);

    bus.ins_ready = 1'b0;
    pc_force      = 1'b1;
    pc_force_val  = 16'd5;
    step(3);
    check("reset_outs", all_outs(), 64'd0);
    rst_n    = 1'b1;
    pc_force = 1'b0;

    // Fetch gating: nothing happens while fetch is low.
    b_rd = rd_cnt;
    step(5);
    check("gate_no_rd", 64'(rd_cnt - b_rd), 64'd0);
    check("gate_idle_busy", 64'(busy), 64'd0);

    b_rd = rd_cnt;
    for (int i = 0; i < 15; i++) begin
      fetch         = tbl[i].fetch;
      bus.ins_ready = tbl[i].ready;
      step(1);
      check($sformatf("vec%0d", i),
            64'({bus.mem_rd, bus.mem_addr, bus.ins_valid, bus.ins_opcode, pc1, ins_con, busy}),
            64'({tbl[i].rd, tbl[i].addr, tbl[i].valid, tbl[i].op, tbl[i].pc1, 1'b0,
                 tbl[i].busy}));
    end
    check("plain_rd_count", 64'(rd_cnt - b_rd), 64'd2);
    check("plain_pc", 64'(pc_addr), 64'd7);

    // Jump at 10 -> target 0x014D, which holds a plain opcode.
    pc_force     = 1'b1;
    pc_force_val = 16'd10;
    step(1);
    pc_force = 1'b0;
    b_rd = rd_cnt; b_pc1 = pc1_cnt; b_con = con_cnt; b_ovl = overlap_cnt; b_wide = wide_cnt;
    fetch = 1'b1;
    wait_valid(40, n, ok);
    check("jump_valid_seen", 64'(ok), 64'd1);
    check("jump_rd_count", 64'(rd_cnt - b_rd), 64'd4);
    check("jump_addr0", 64'(rd_addr[5'(b_rd)]), 64'd10);
    check("jump_addr1", 64'(rd_addr[5'(b_rd + 1)]), 64'd11);
    check("jump_addr2", 64'(rd_addr[5'(b_rd + 2)]), 64'd12);
    check("jump_addr3", 64'(rd_addr[5'(b_rd + 3)]), 64'h014D);
    check("jump_pc1_count", 64'(pc1_cnt - b_pc1), 64'd2);
    check("jump_con_count", 64'(con_cnt - b_con), 64'd1);
    check("jump_overlap", 64'(overlap_cnt - b_ovl), 64'd0);
    check("jump_wide", 64'(wide_cnt - b_wide), 64'd0);
    check("jump_tr_mbr", 64'({tr_pc, mbr_pc}), 64'h014D);
    check("jump_target_op", 64'(bus.ins_opcode), 64'h05);

    // Finish raised while the opcode at 333 is presented.
    finish_signal = 1'b1;
    b_rd = rd_cnt; b_pc1 = pc1_cnt; b_con = con_cnt;
    step(1);
    check("finish_hold_valid", 64'(bus.ins_valid), 64'd1);
    bus.ins_ready = 1'b1;
    step(1);
    bus.ins_ready = 1'b0;
    check("finish_handshake", 64'({bus.ins_valid, pc1}), 64'b01);
    step(20);
    check("finish_pc1_count", 64'(pc1_cnt - b_pc1), 64'd1);
    check("finish_con_count", 64'(con_cnt - b_con), 64'd0);
    check("finish_no_rd", 64'(rd_cnt - b_rd), 64'd0);
    check("finish_halted_busy", 64'({halted, busy}), 64'b10);

    // Asynchronous reset leaves HALTED and clears every output, including the jump target.
    rst_n = 1'b0;
    #1;
    check("halt_reset_outs", all_outs(), 64'd0);
    finish_signal = 1'b0;
    pc_force      = 1'b1;
    pc_force_val  = 16'd30;
    lat           = 4;
    step(2);
    rst_n    = 1'b1;
    pc_force = 1'b0;

    // Reset in the middle of WAIT_OP, followed by a stray rvalid.
    n  = 0;
    ok = 1'b0;
    while (n < 10 && !ok) begin
      step(1);
      n++;
      if (bus.mem_rd) ok = 1'b1;
    end
    check("rst_rd_seen", 64'(ok), 64'd1);
    step(2);
    rst_n = 1'b0;
    fetch = 1'b0;
    #1;
    check("midwait_reset_outs", all_outs(), 64'd0);
    step(2);
    rst_n = 1'b1;
    b_rd = rd_cnt; b_pc1 = pc1_cnt;
    spur = 1'b1;
    step(1);
    spur = 1'b0;
    step(6);
    check("late_rvalid_ignored",
          64'({bus.ins_valid, bus.ins_opcode, busy, halted}), 64'd0);
    check("late_rvalid_quiet", 64'({rd_cnt - b_rd, pc1_cnt - b_pc1}), 64'd0);

    // Five-cycle memory latency, then a stray rvalid during PRESENT.
    pc_force     = 1'b1;
    pc_force_val = 16'd20;
    lat          = 5;
    step(1);
    pc_force = 1'b0;
    b_rd = rd_cnt; b_pc1 = pc1_cnt;
    fetch = 1'b1;
    wait_valid(30, n, ok);
    check("lat_valid_seen", 64'(ok), 64'd1);
    check("lat_cycles", 64'(n), 64'd8);
    check("lat_rd_once", 64'(rd_cnt - b_rd), 64'd1);
    check("lat_no_pc1", 64'(pc1_cnt - b_pc1), 64'd0);
    check("lat_opcode", 64'(bus.ins_opcode), 64'h09);
    spur = 1'b1;
    step(1);
    spur = 1'b0;
    check("present_spur_ignored", 64'({bus.ins_valid, bus.ins_opcode}), 64'h109);
    fetch         = 1'b0;
    bus.ins_ready = 1'b1;
    step(1);
    bus.ins_ready = 1'b0;
    check("lat_handshake", 64'({bus.ins_valid, pc1}), 64'b01);
    step(3);
    check("lat_end_idle", 64'({busy, halted, bus.mem_rd}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
